store_unit: RTL
===============

// Module: store_unit
// PURPOSE
//  Write-side counterpart of the byte-serial instruction fetch path. Accepts one store request
//  (byte/half/word) from the execute stage and serialises it into single-byte memory writes.
//  Writes are big-endian, MSB first: byte k of an n-byte store goes to addr+k.
//  Sits between the execute stage and the byte-wide data memory write port.
// PARAMETERS
//  DATA_WIDTH  `DATA_WIDTH (8)  memory data port width; only 8 is supported
//  ADDR_WIDTH  32               address width; address arithmetic wraps modulo 2^ADDR_WIDTH
// PORTS
//  i_clk        in   1           clock
//  i_rst        in   1           synchronous reset, active-high
//  i_req_valid  in   1           store request present
//  o_req_ready  out  1           unit idle, request accepted when valid&ready at posedge
//  i_addr       in   ADDR_WIDTH  store base address
//  i_data       in   32          store data; the low n bytes are used
//  i_size       in   2           0=byte, 1=half, 2=word, 3=reserved
//  o_mem_addr   out  ADDR_WIDTH  memory write address
//  o_mem_data   out  DATA_WIDTH  memory write byte
//  o_mem_we     out  1           memory write enable; one byte is written per cycle while high
//  o_busy       out  1           request in flight (state != IDLE)
//  o_done       out  1           one-cycle completion pulse
//  o_err        out  1           one-cycle error pulse, coincident with o_done (macro only, else 0)
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, addr_q=0, data_q=0, n_q=0.
//    Outputs after reset: o_req_ready=1, o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_busy=0, o_done=0, o_err=0.
//  - FSM IDLE -> WRITE -> DONE -> IDLE.
//    - IDLE: o_req_ready=1. On valid, latch addr/data and n_q (1/2/4 bytes; size 3 -> 4 bytes), then go to WRITE with cnt=0.
//    - WRITE: o_mem_we=1, o_mem_addr=addr_q+cnt, o_mem_data=data_q[(n_q-cnt)*8-1 -: 8].
//      cnt increments each cycle; when cnt==n_q-1, go to DONE and clear cnt.
//    - DONE: o_done=1 for exactly one cycle, o_req_ready=0, then go to IDLE.
//  - All outputs decode from registered state; there is no combinational path from inputs to outputs.
//  - Latency, with accept edge = cycle 0: word writes in cycles 1-4 and o_done in cycle 5;
//    half: writes 1-2, done 3; byte: write 1, done 2.
//  - Max throughput: one request per n+2 cycles. Ready is low during WRITE and DONE.
//    i_* inputs are ignored then; changes to them do not affect the store in flight.
//  - Address wrap: addr_q+cnt wraps modulo 2^ADDR_WIDTH, e.g. FFFFFFFF -> 00000000.
//  - Reset mid-operation: the FSM goes straight to IDLE and o_mem_we=0 in the cycle after the reset edge.
//    Bytes already written are not rolled back, and no o_done is issued.
//  - Reset and valid together: reset wins; the request is not accepted.
// CONFIGURATION
//  STORE_ALIGN_CHECK_EN defined:
//    - A request is faulty if it is a misaligned half (addr[0]!=0), a misaligned word (addr[1:0]!=0), or size==3.
//    - A faulty request is accepted but goes IDLE -> DONE directly, with no writes.
//    - In the DONE cycle, o_done=1 and o_err=1.
//  STORE_ALIGN_CHECK_EN undefined:
//    - o_err is tied to 0 and no alignment check is made.
//    - Any address is written as given; size 3 is treated as a word.
// STRUCTURE
//  - Shared package leg_mem_pkg:
//    - typedef enum logic[1:0] mem_size_t {MEM_SZ_BYTE, MEM_SZ_HALF, MEM_SZ_WORD, MEM_SZ_RSVD};
//    - localparam WORD_BYTES=4;
//    - function size_to_bytes(mem_size_t).
//  - The state enum {ST_IDLE, ST_WRITE, ST_DONE} stays local to this module.
//  - One sub-module, store_byte_sel: combinational (data_q, n_q, cnt) -> byte. Reusable by a future load aligner.
// TESTING
//  1. Word store, addr 0x1000, data DEADBEEF:
//     cycles 1-4 write (1000,DE) (1001,AD) (1002,BE) (1003,EF); o_done in cycle 5; ready=1 in cycle 6.
//  2. Byte store, addr 0x20, data 12345678: single write (20,78) in cycle 1; o_done in cycle 2.
//     Half store, addr 0x22, data AABBCCDD: writes (22,CC) (23,DD); o_done in cycle 3.
//  3. Word store at FFFFFFFE, data 01020304:
//     addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001 get 01, 02, 03, 04.
//  4. Reset after the 2nd byte of a word store: o_mem_we=0 the next cycle; o_done is never pulsed;
//     ready=1 after reset is released; a new store then completes normally.
//  5. Back-to-back with valid held high and inputs changed mid-store:
//     - the first store writes its latched data unchanged;
//     - the second store is accepted in the IDLE cycle after DONE (no overlap).
//  6. STORE_ALIGN_CHECK_EN, word store at 0x1001: o_mem_we never asserts; o_done=o_err=1 in cycle 1.
//     Without the macro, the same store writes 1001..1004 and o_err stays 0.

Source files
------------

// File: rtl/leg_mem_pkg.sv
// Shared memory-access definitions for the byte-serial load/store paths.
package leg_mem_pkg;

   typedef enum logic [1:0] {
      MEM_SZ_BYTE,
      MEM_SZ_HALF,
      MEM_SZ_WORD,
      MEM_SZ_RSVD
   } mem_size_t;

   localparam int WORD_BYTES = 4;

   // The reserved encoding is treated as a full word.
   function automatic logic [2:0] size_to_bytes(input mem_size_t sz);
      logic [2:0] n;
      case (sz)
         MEM_SZ_BYTE: n = 3'd1;
         MEM_SZ_HALF: n = 3'd2;
         default:     n = 3'(WORD_BYTES);
      endcase
      return n;
   endfunction

endpackage

// File: rtl/store_byte_sel.sv
// Picks the byte of an n-byte big-endian value that goes out at position cnt (MSB first).
module store_byte_sel (
   input  logic [31:0] data_i,
   input  logic [2:0]  n_i,
   input  logic [1:0]  cnt_i,
   output logic [7:0]  byte_o
);

   logic [1:0] idx;
   logic [4:0] lsb;

   // Byte cnt of an n-byte value sits at byte lane n-1-cnt.
   assign idx    = 2'(n_i - 3'd1) - cnt_i;
   assign lsb    = {idx, 3'b000};
   assign byte_o = data_i[lsb +: 8];

endmodule

// File: rtl/store_unit.sv
// Serialises one byte/half/word store into big-endian byte writes.
// Optional STORE_ALIGN_CHECK_EN: misaligned or reserved-size stores complete with o_err and no writes.
module store_unit
   import leg_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_data,
   input  logic [1:0]            i_size,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   output logic                  o_mem_we,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic [2:0]            n_q, n_d;
   logic                  faulty;
   logic [7:0]            sel_byte;

`ifdef STORE_ALIGN_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      faulty = 1'b0;
      case (mem_size_t'(i_size))
         MEM_SZ_HALF: faulty = i_addr[0];
         MEM_SZ_WORD: faulty = (i_addr[1:0] != 2'b00);
         MEM_SZ_RSVD: faulty = 1'b1;
         default:     faulty = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign o_err = (state_q == ST_DONE) && err_q;
`else
   assign faulty = 1'b0;
   assign o_err  = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         n_q     <= n_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      n_d         = n_q;
`ifdef STORE_ALIGN_CHECK_EN
      err_d       = err_q;
`endif
      o_req_ready = 1'b0;
      o_mem_we    = 1'b0;
      o_busy      = 1'b1;
      o_done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            o_busy      = 1'b0;
            if (i_req_valid) begin
               addr_d  = i_addr;
               data_d  = i_data;
               n_d     = size_to_bytes(mem_size_t'(i_size));
               cnt_d   = '0;
`ifdef STORE_ALIGN_CHECK_EN
               err_d   = faulty;
`endif
               state_d = faulty ? ST_DONE : ST_WRITE;
            end
         end
         ST_WRITE: begin
            o_mem_we = 1'b1;
            if ({1'b0, cnt_q} == n_q - 3'd1) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         ST_DONE: begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   store_byte_sel u_byte_sel (
      .data_i (data_q),
      .n_i    (n_q),
      .cnt_i  (cnt_q),
      .byte_o (sel_byte)
   );

   // Address and data lines are held at zero outside write cycles.
   assign o_mem_addr = o_mem_we ? addr_q + ADDR_WIDTH'(cnt_q) : '0;
   assign o_mem_data = o_mem_we ? sel_byte : '0;

endmodule
